sram_ctrl: RTL and testbench



---
 rtl/sram_ctrl_if.sv | 26 ++
 rtl/sram_ctrl.sv | 104 ++++++++++
 tb/tb_sram_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: CPU-side and SRAM-side signals of the data-memory controller
// slave  : the controller (sram_ctrl)
// master : the pipeline MEM stage plus the external SRAM pins
interface sram_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        freeze;
    logic        err;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, freeze, err, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
    );
    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, freeze, err, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
    );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences 32-bit MEM-stage loads/stores as two half-word phases on a 16-bit SRAM
// clk, rst        : rising-edge clock, asynchronous active-high reset
// bus.wr_en/rd_en : store/load request (store wins when both are set)
// bus.address     : CPU byte address, BASE_ADDR maps to SRAM word 0
// bus.write_data  : store data; bus.read_data: registered load result
// bus.ready       : access complete; bus.freeze = ~ready stalls IF/ID/EXE
// bus.err         : sticky address error, only with SRAM_CTRL_ADDR_CHECK_EN defined
// bus.sram_*      : half-word address, active-low write strobe, data out/enable, data in
// Optional macro SRAM_CTRL_ADDR_CHECK_EN: reject out-of-range/misaligned requests
module sram_ctrl #(
    parameter int          PHASE_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR    = 32'd1024
) (
    input logic      clk,
    input logic      rst,
    sram_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        op_wr, op_wr_n;
    logic [31:0] read_data;
    logic [16:0] word;
    logic        req, last, drive, cap_lo, cap_hi, bad;
    assign req  = bus.wr_en | bus.rd_en;
    assign word = 17'((bus.address - BASE_ADDR) >> 2);
    assign last = cnt == 4'(PHASE_CYCLES - 1);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    logic [14:0] word_hi;
    logic        err_q;
    assign word_hi = 15'((bus.address - BASE_ADDR) >> 19);
    assign bad = (bus.address < BASE_ADDR) || (bus.address[1:0] != 2'b00) || (word_hi != '0);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            err_q <= 1'b0;
        else if (state == IDLE && req && bad)
            err_q <= 1'b1;
    assign bus.err = err_q;
`else
    assign bad     = 1'b0;
    assign bus.err = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_wr     <= 1'b0;
            read_data <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_wr <= op_wr_n;
            if (cap_lo)
                read_data[15:0] <= bus.sram_dq_in;
            if (cap_hi)
                read_data[31:16] <= bus.sram_dq_in;
        end
    // A dropped request in LOW/HIGH aborts straight back to IDLE without capturing
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_wr_n = op_wr;
        cap_lo  = 1'b0;
        cap_hi  = 1'b0;
        case (state)
            IDLE:
                if (req) begin
                    state_n = bad ? DONE : LOW;
                    cnt_n   = 4'd0;
                    op_wr_n = bus.wr_en;
                end
            LOW:
                if (!req) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else if (last) begin
                    state_n = HIGH;
                    cnt_n   = 4'd0;
                    cap_lo  = !op_wr;
                end else
                    cnt_n = cnt + 4'd1;
            HIGH:
                if (!req) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else if (last) begin
                    state_n = DONE;
                    cnt_n   = 4'd0;
                    cap_hi  = !op_wr;
                end else
                    cnt_n = cnt + 4'd1;
            default: state_n = IDLE;
        endcase
    end
    // Strobe is gated by the live request so an abort releases the bus in the same cycle
    assign drive           = (state == LOW || state == HIGH) && op_wr && req;
    assign bus.sram_we_n   = !drive;
    assign bus.sram_dq_oe  = drive;
    assign bus.sram_dq_out = drive ? (state == HIGH ? bus.write_data[31:16] : bus.write_data[15:0]) : 16'h0;
    assign bus.sram_addr   = {word, state == HIGH};
    assign bus.ready       = !req || state == DONE;
    assign bus.freeze      = !bus.ready;
    assign bus.read_data   = read_data;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: timeline model plus directed vectors for sram_ctrl
module tb_sram_ctrl;
    localparam int P = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    sram_ctrl_if bus();
    sram_ctrl #(.PHASE_CYCLES(P), .BASE_ADDR(32'd1024)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic [15:0] sram [0:63];
    assign bus.sram_dq_in = sram[bus.sram_addr[5:0]];
    initial begin
        for (int i = 0; i < 64; i++) sram[i] = 16'h0;
        sram[4] = 16'h5678;
        sram[5] = 16'h1234;
        forever begin
            @(posedge clk);
            if (!bus.sram_we_n) sram[bus.sram_addr[5:0]] <= bus.sram_dq_out;
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask
    // Model: pos counts cycles into an access (0 = idle, 1..P low, P+1..2P high, 2P+1 done)
    int          pos = 0;
    bit          op = 0, r, hi, act, bad;
    logic [31:0] w, exp_rd = 32'h0;
    logic        exp_err = 1'b0;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    logic [15:0] ref_mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0;
        ref_mem[4] = 16'h5678;
        ref_mem[5] = 16'h1234;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                pos = 0; op = 0; exp_rd = 32'h0; exp_err = 1'b0;
            end else begin
                r = bus.wr_en | bus.rd_en;
                w = (bus.address - 32'd1024) >> 2;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
                bad = bus.address < 32'd1024 || bus.address[1:0] != 2'b00 || ((bus.address - 32'd1024) >> 19) != 0;
`else
                bad = 1'b0;
`endif
                hi = pos > P && pos <= 2 * P;
                act = pos >= 1 && pos <= 2 * P && r && op;
                e_addr = {w[16:0], hi};
                e_dq = act ? (hi ? bus.write_data[31:16] : bus.write_data[15:0]) : 16'h0;
                chk("m_ready", bus.ready, !r || pos == 2 * P + 1);
                chk("m_freeze", bus.freeze, r && pos != 2 * P + 1);
                chk("m_we_n", bus.sram_we_n, !act);
                chk("m_oe", bus.sram_dq_oe, act);
                chk("m_dq_out", bus.sram_dq_out, e_dq);
                chk("m_sram_addr", bus.sram_addr, e_addr);
                chk("m_read_data", bus.read_data, exp_rd);
                chk("m_err", bus.err, exp_err);
                if (act) ref_mem[e_addr[5:0]] = e_dq;
                if (pos == 0) begin
                    if (r) begin
                        op = bus.wr_en;
                        pos = bad ? 2 * P + 1 : 1;
                        if (bad) exp_err = 1'b1;
                    end
                end else if (pos == 2 * P + 1 || !r)
                    pos = 0;
                else begin
                    if (!op && pos == P) exp_rd[15:0] = ref_mem[{w[4:0], 1'b0}];
                    if (!op && pos == 2 * P) exp_rd[31:16] = ref_mem[{w[4:0], 1'b1}];
                    pos++;
                end
            end
        end
    end
    task automatic tick; @(posedge clk); #1; endtask
    task automatic mid; @(negedge clk); endtask
    task automatic req(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        bus.wr_en = wr; bus.rd_en = rd; bus.address = a; bus.write_data = d;
    endtask
    initial begin
        req(0, 0, 32'h0, 32'h0);
        tick; tick;
        rst = 1'b0;
        mid;
        chk("rst_ready", bus.ready, 1);
        chk("rst_read_data", bus.read_data, 0);
        chk("rst_we_n", bus.sram_we_n, 1);
        chk("rst_oe", bus.sram_dq_oe, 0);
        tick;
        req(1, 0, 32'd1028, 32'hDEADBEEF);
        for (int c = 0; c <= 5; c++) begin
            mid;
            chk("wr_freeze", bus.freeze, c < 5);
            chk("wr_addr", bus.sram_addr, (c == 3 || c == 4) ? 3 : 2);
            chk("wr_dq", bus.sram_dq_out, (c == 0 || c == 5) ? 0 : (c < 3 ? 32'hBEEF : 32'hDEAD));
            chk("wr_we_n", bus.sram_we_n, c == 0 || c == 5);
            tick;
        end
        req(1'b0, 1'b1, 32'd1032, 32'h0);
        for (int c = 0; c <= 5; c++) begin
            mid;
            chk("rd_ready", bus.ready, c == 5);
            if (c == 5) chk("rd_data", bus.read_data, 32'h12345678);
            tick;
        end
        req(0, 0, 32'd1032, 32'h0);
        tick; tick; mid;
        chk("rd_hold", bus.read_data, 32'h12345678);
        tick;
        req(1, 1, 32'd1036, 32'hCAFEF00D);
        for (int c = 0; c <= 11; c++) begin
            mid;
            chk("b2b_ready", bus.ready, c == 5 || c == 11);
            if (c == 1) chk("prio_we_n", bus.sram_we_n, 0);
            if (c == 5) chk("prio_nocap", bus.read_data, 32'h12345678);
            tick;
        end
        req(0, 1, 32'd1036, 32'h0);
        for (int c = 0; c <= 5; c++) begin
            mid;
            if (c == 5) chk("prio_readback", bus.read_data, 32'hCAFEF00D);
            tick;
        end
        req(1, 0, 32'd1040, 32'h11112222);
        mid; tick;
        mid;
        chk("ab_we_n_c1", bus.sram_we_n, 0);
        tick;
        req(0, 0, 32'd1040, 32'h11112222);
        mid;
        chk("ab_we_n_c2", bus.sram_we_n, 1);
        chk("ab_oe_c2", bus.sram_dq_oe, 0);
        tick;
        req(0, 1, 32'd1032, 32'h0);
        for (int c = 0; c <= 5; c++) begin
            mid;
            chk("ab_restart_ready", bus.ready, c == 5);
            if (c == 5) chk("ab_restart_data", bus.read_data, 32'h12345678);
            tick;
        end
        req(1, 0, 32'd1028, 32'hDEADBEEF);
        mid; tick;
        mid;
        chk("mrst_we_pre", bus.sram_we_n, 0);
        #1 rst = 1'b1;
        #1;
        chk("mrst_we_n", bus.sram_we_n, 1);
        chk("mrst_oe", bus.sram_dq_oe, 0);
        chk("mrst_read_data", bus.read_data, 0);
        tick;
        req(0, 0, 32'd1028, 32'h0);
        tick;
        rst = 1'b0;
        mid;
        chk("mrst_after_rd", bus.read_data, 0);
        chk("mrst_after_ready", bus.ready, 1);
        tick;
        req(0, 1, 32'd1028, 32'h0);
        for (int c = 0; c <= 5; c++) begin
            mid;
            chk("mrst_rd_ready", bus.ready, c == 5);
            if (c == 5) chk("mrst_rd_data", bus.read_data, 32'hDEADBEEF);
            tick;
        end
        req(0, 0, 32'd1028, 32'h0);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
        tick;
        req(0, 1, 32'd1026, 32'h0);
        mid;
        chk("err_ready_c0", bus.ready, 0);
        tick;
        mid;
        chk("err_ready_c1", bus.ready, 1);
        chk("err_flag", bus.err, 1);
        chk("err_we_n", bus.sram_we_n, 1);
        chk("err_rd_kept", bus.read_data, 32'hDEADBEEF);
        tick;
        req(0, 0, 32'd1026, 32'h0);
        tick; mid;
        chk("err_sticky", bus.err, 1);
`else
        tick; mid;
        chk("err_tied", bus.err, 0);
`endif
        tick; tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
